// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for ARM data-processing instructions.
// Accepts a decoded instruction, checks its condition against the flag
// register, drives the external combinational ALU from latched operands,
// commits flags when S is set and hands the result to the register-file
// writeback port.
module alu_exec_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_Valid,
  output logic             out_Ready,
  input  logic [3:0]       in_Cond,
  input  logic [3:0]       in_Opcode,
  input  logic             in_SetFlags,
  input  logic [3:0]       in_Rd,
  input  logic [WIDTH-1:0] in_Rn_Val,
  input  logic [WIDTH-1:0] in_Op2_Val,
  input  logic             in_ShiftCarry,
  output logic [WIDTH-1:0] out_AluRn,
  output logic [WIDTH-1:0] out_AluOp2,
  output logic             out_AluCarry,
  output logic [3:0]       out_AluOpcode,
  input  logic [WIDTH-1:0] in_AluY,
  input  logic [3:0]       in_AluCNZV,
  output logic             out_WbValid,
  output logic [3:0]       out_WbRd,
  output logic [WIDTH-1:0] out_WbData,
  input  logic             in_WbReady,
  output logic [3:0]       out_CNZV,
  output logic             out_Skip
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  // Flag vector layout: [3]=C, [2]=N, [1]=Z, [0]=V.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic c_s, n_s, z_s, v_s, res_s;
    c_s = f[3];
    n_s = f[2];
    z_s = f[1];
    v_s = f[0];
    case (cond)
      4'h0:    res_s = z_s;
      4'h1:    res_s = !z_s;
      4'h2:    res_s = c_s;
      4'h3:    res_s = !c_s;
      4'h4:    res_s = n_s;
      4'h5:    res_s = !n_s;
      4'h6:    res_s = v_s;
      4'h7:    res_s = !v_s;
      4'h8:    res_s = c_s & !z_s;
      4'h9:    res_s = !c_s | z_s;
      4'hA:    res_s = (n_s == v_s);
      4'hB:    res_s = (n_s != v_s);
      4'hC:    res_s = !z_s & (n_s == v_s);
      4'hD:    res_s = z_s | (n_s != v_s);
      4'hE:    res_s = 1'b1;
      default: res_s = 1'b0;  // 1111: never executes
    endcase
    return res_s;
  endfunction

  // SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN take all four flags from the ALU.
  function automatic logic is_arith(input logic [3:0] op);
    return ((op >= 4'h2) && (op <= 4'h7)) || (op == 4'hA) || (op == 4'hB);
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       cond_q, cond_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             s_q, s_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] rn_q, rn_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             shc_q, shc_d;
  logic [3:0]       wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       cnzv_q, cnzv_d;
  logic             skip_q, skip_d;
  logic             wb_valid_q, wb_valid_d;
  logic             ready_q, ready_d;

  // Next-state and datapath-capture logic for the IDLE/EXEC/WB sequencer.
  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    opcode_d   = opcode_q;
    s_d        = s_q;
    rd_d       = rd_q;
    rn_d       = rn_q;
    op2_d      = op2_q;
    shc_d      = shc_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    cnzv_d     = cnzv_q;
    skip_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_Valid) begin
          cond_d   = in_Cond;
          opcode_d = in_Opcode;
          s_d      = in_SetFlags;
          rd_d     = in_Rd;
          rn_d     = in_Rn_Val;
          op2_d    = in_Op2_Val;
          shc_d    = in_ShiftCarry;
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (!cond_holds(cond_q, cnzv_q)) begin
          skip_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (s_q) begin
            if (is_arith(opcode_q)) begin
              cnzv_d = in_AluCNZV;
            end else begin
              // Logical ops: carry comes from the shifter, overflow is untouched.
              cnzv_d = {shc_q, in_AluCNZV[2], in_AluCNZV[1], cnzv_q[0]};
            end
          end else begin
            cnzv_d = cnzv_q;
          end
          if (opcode_q[3:2] == 2'b10) begin
            state_d = ST_IDLE;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = in_AluY;
            state_d   = ST_WB;
          end
        end
      end
      ST_WB: begin
        if (in_WbReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wb_valid_d = (state_d == ST_WB);
    ready_d    = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q    <= ST_IDLE;
      cond_q     <= 4'h0;
      opcode_q   <= 4'h0;
      s_q        <= 1'b0;
      rd_q       <= 4'h0;
      rn_q       <= {WIDTH{1'b0}};
      op2_q      <= {WIDTH{1'b0}};
      shc_q      <= 1'b0;
      wb_rd_q    <= 4'h0;
      wb_data_q  <= {WIDTH{1'b0}};
      cnzv_q     <= 4'h0;
      skip_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      opcode_q   <= opcode_d;
      s_q        <= s_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      op2_q      <= op2_d;
      shc_q      <= shc_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      cnzv_q     <= cnzv_d;
      skip_q     <= skip_d;
      wb_valid_q <= wb_valid_d;
      ready_q    <= ready_d;
    end
  end

  assign out_Ready     = ready_q;
  assign out_AluRn     = rn_q;
  assign out_AluOp2    = op2_q;
  assign out_AluOpcode = opcode_q;
  assign out_AluCarry  = cnzv_q[3];
  assign out_WbValid   = wb_valid_q;
  assign out_WbRd      = wb_rd_q;
  assign out_WbData    = wb_data_q;
  assign out_CNZV      = cnzv_q;
  assign out_Skip      = skip_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural ARM ALU closes the
// loop, a directed table walks the documented scenarios, then randomized
// instructions are checked against an instruction-level reference model.
module tb_alu_exec_ctrl;
  localparam int W = 32;

  logic         in_Clk = 1'b0;
  logic         in_Rst_N = 1'b0;
  logic         in_Valid = 1'b0;
  logic         out_Ready;
  logic [3:0]   in_Cond = 4'h0;
  logic [3:0]   in_Opcode = 4'h0;
  logic         in_SetFlags = 1'b0;
  logic [3:0]   in_Rd = 4'h0;
  logic [W-1:0] in_Rn_Val = '0;
  logic [W-1:0] in_Op2_Val = '0;
  logic         in_ShiftCarry = 1'b0;
  logic [W-1:0] out_AluRn, out_AluOp2;
  logic         out_AluCarry;
  logic [3:0]   out_AluOpcode;
  logic [W-1:0] in_AluY;
  logic [3:0]   in_AluCNZV;
  logic         out_WbValid;
  logic [3:0]   out_WbRd;
  logic [W-1:0] out_WbData;
  logic         in_WbReady = 1'b0;
  logic [3:0]   out_CNZV;
  logic         out_Skip;

  int passed = 0;
  int total  = 0;
  logic [3:0] flags_m = 4'h0;

  typedef struct {
    logic [3:0]   cond;
    logic [3:0]   op;
    logic         s;
    logic [3:0]   rd;
    logic [W-1:0] rn;
    logic [W-1:0] op2;
    logic         shc;
    logic         exp_skip;
    logic         exp_wb;
    logic [W-1:0] exp_data;
    logic [3:0]   exp_cnzv;
    int           stall;
  } vec_t;

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .in_Clk(in_Clk), .in_Rst_N(in_Rst_N), .in_Valid(in_Valid), .out_Ready(out_Ready),
    .in_Cond(in_Cond), .in_Opcode(in_Opcode), .in_SetFlags(in_SetFlags), .in_Rd(in_Rd),
    .in_Rn_Val(in_Rn_Val), .in_Op2_Val(in_Op2_Val), .in_ShiftCarry(in_ShiftCarry),
    .out_AluRn(out_AluRn), .out_AluOp2(out_AluOp2), .out_AluCarry(out_AluCarry),
    .out_AluOpcode(out_AluOpcode), .in_AluY(in_AluY), .in_AluCNZV(in_AluCNZV),
    .out_WbValid(out_WbValid), .out_WbRd(out_WbRd), .out_WbData(out_WbData),
    .in_WbReady(in_WbReady), .out_CNZV(out_CNZV), .out_Skip(out_Skip)
  );

  always #5 in_Clk = ~in_Clk;

  // x + y + c with ARM-style C (carry out) and V (signed overflow); returns {C,N,Z,V,y}.
  function automatic logic [W+3:0] add3(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] sum;
    logic [W-1:0] r;
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r = sum[W-1:0];
    return {sum[W], r[W-1], (r == '0), (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), r};
  endfunction

  function automatic logic [W+3:0] logic_res(input logic [W-1:0] r);
    return {1'b0, r[W-1], (r == '0), 1'b0, r};
  endfunction

  // Behavioural ARM data-processing ALU.
  function automatic logic [W+3:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    case (op)
      4'h0: return logic_res(a & b);
      4'h1: return logic_res(a ^ b);
      4'h2: return add3(a, ~b, 1'b1);
      4'h3: return add3(b, ~a, 1'b1);
      4'h4: return add3(a, b, 1'b0);
      4'h5: return add3(a, b, cin);
      4'h6: return add3(a, ~b, cin);
      4'h7: return add3(b, ~a, cin);
      4'h8: return logic_res(a & b);
      4'h9: return logic_res(a ^ b);
      4'hA: return add3(a, ~b, 1'b1);
      4'hB: return add3(a, b, 1'b0);
      4'hC: return logic_res(a | b);
      4'hD: return logic_res(b);
      4'hE: return logic_res(a & ~b);
      default: return logic_res(~b);
    endcase
  endfunction

  logic [W+3:0] alu_r;
  // Environment ALU feeding the controller.
  always_comb begin
    alu_r      = alu_ref(out_AluOpcode, out_AluRn, out_AluOp2, out_AluCarry);
    in_AluY    = alu_r[W-1:0];
    in_AluCNZV = alu_r[W+3:W];
  end

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic c, n, z, v;
    {c, n, z, v} = f;
    case (cond)
      4'h0: return z;           4'h1: return !z;
      4'h2: return c;           4'h3: return !c;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return c && !z;     4'h9: return !c || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: fills the expected fields of v from flags f.
  function automatic vec_t ref_exec(input vec_t v, input logic [3:0] f);
    vec_t o;
    logic [W+3:0] r;
    logic arith;
    o = v;
    o.exp_cnzv = f;
    o.exp_skip = 1'b0;
    o.exp_wb   = 1'b0;
    o.exp_data = '0;
    if (!cond_ok(v.cond, f)) begin
      o.exp_skip = 1'b1;
    end else begin
      r = alu_ref(v.op, v.rn, v.op2, f[3]);
      arith = (v.op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB});
      if (v.s) o.exp_cnzv = arith ? r[W+3:W] : {v.shc, r[W+2], r[W+1], f[0]};
      if (!(v.op inside {4'h8, 4'h9, 4'hA, 4'hB})) begin
        o.exp_wb   = 1'b1;
        o.exp_data = r[W-1:0];
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one instruction from IDLE and follow it to completion.
  task automatic issue(input vec_t v);
    chk("ready_idle", {63'd0, out_Ready}, 64'd1);
    in_Cond = v.cond; in_Opcode = v.op; in_SetFlags = v.s; in_Rd = v.rd;
    in_Rn_Val = v.rn; in_Op2_Val = v.op2; in_ShiftCarry = v.shc; in_Valid = 1'b1;
    @(posedge in_Clk); #1;
    in_Valid = 1'b0;
    chk("ready_exec", {63'd0, out_Ready}, 64'd0);
    chk("alu_opcode", {60'd0, out_AluOpcode}, {60'd0, v.op});
    chk("alu_rn", {32'd0, out_AluRn}, {32'd0, v.rn});
    chk("alu_op2", {32'd0, out_AluOp2}, {32'd0, v.op2});
    chk("alu_carry", {63'd0, out_AluCarry}, {63'd0, flags_m[3]});
    chk("skip_exec", {63'd0, out_Skip}, 64'd0);
    @(posedge in_Clk); #1;
    chk("skip", {63'd0, out_Skip}, {63'd0, v.exp_skip});
    chk("wb_valid", {63'd0, out_WbValid}, {63'd0, v.exp_wb});
    chk("cnzv", {60'd0, out_CNZV}, {60'd0, v.exp_cnzv});
    flags_m = v.exp_cnzv;
    if (v.exp_wb) begin
      chk("wb_rd", {60'd0, out_WbRd}, {60'd0, v.rd});
      chk("wb_data", {32'd0, out_WbData}, {32'd0, v.exp_data});
      chk("ready_wb", {63'd0, out_Ready}, 64'd0);
      for (int i = 0; i < v.stall; i++) begin
        if (i == 0) begin
          in_Valid = 1'b1; in_Opcode = ~v.op; in_Rn_Val = ~v.rn;
        end
        @(posedge in_Clk); #1;
        chk("stall_valid", {63'd0, out_WbValid}, 64'd1);
        chk("stall_rd", {60'd0, out_WbRd}, {60'd0, v.rd});
        chk("stall_data", {32'd0, out_WbData}, {32'd0, v.exp_data});
        chk("stall_ready", {63'd0, out_Ready}, 64'd0);
      end
      in_Valid = 1'b0;
      in_WbReady = 1'b1;
      @(posedge in_Clk); #1;
      in_WbReady = 1'b0;
      chk("wb_done", {63'd0, out_WbValid}, 64'd0);
      chk("ready_after_wb", {63'd0, out_Ready}, 64'd1);
      chk("alu_opcode_held", {60'd0, out_AluOpcode}, {60'd0, v.op});
    end else begin
      chk("ready_after", {63'd0, out_Ready}, 64'd1);
    end
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    //          cond  op    s     rd    rn            op2           shc   skip  wb    data          cnzv  stall
    tbl[0]  = '{4'hE, 4'h4, 1'b0, 4'h5, 32'd2,        32'd3,        1'b0, 1'b0, 1'b1, 32'd5,        4'h0, 0}; // ADD
    tbl[1]  = '{4'hE, 4'h2, 1'b1, 4'h1, 32'd5,        32'd5,        1'b0, 1'b0, 1'b1, 32'd0,        4'hA, 0}; // SUBS
    tbl[2]  = '{4'h0, 4'h4, 1'b0, 4'h2, 32'd1,        32'd1,        1'b0, 1'b0, 1'b1, 32'd2,        4'hA, 0}; // ADDEQ
    tbl[3]  = '{4'h1, 4'h4, 1'b0, 4'h3, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0, 32'd0,        4'hA, 0}; // ADDNE
    tbl[4]  = '{4'hE, 4'hA, 1'b1, 4'h0, 32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 32'd0,        4'h4, 0}; // CMP 1,2
    tbl[5]  = '{4'hE, 4'hA, 1'b1, 4'h0, 32'd2,        32'd1,        1'b0, 1'b0, 1'b0, 32'd0,        4'h8, 0}; // CMP 2,1
    tbl[6]  = '{4'hE, 4'h5, 1'b0, 4'h7, 32'd1,        32'd1,        1'b0, 1'b0, 1'b1, 32'd3,        4'h8, 4}; // ADC + stall
    tbl[7]  = '{4'hE, 4'h8, 1'b0, 4'h0, 32'hFF,       32'hFF,       1'b0, 1'b0, 1'b0, 32'd0,        4'h8, 0}; // TST, S=0
    tbl[8]  = '{4'hF, 4'hD, 1'b0, 4'h4, 32'd0,        32'd9,        1'b0, 1'b1, 1'b0, 32'd0,        4'h8, 0}; // never
    tbl[9]  = '{4'hE, 4'h4, 1'b1, 4'h6, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 1'b1, 32'h80000000, 4'h5, 0}; // ADDS ovf
    tbl[10] = '{4'hE, 4'hD, 1'b1, 4'h8, 32'd7,        32'd0,        1'b1, 1'b0, 1'b1, 32'd0,        4'hB, 2}; // MOVS

    // Reset state.
    #2;
    chk("rst_cnzv", {60'd0, out_CNZV}, 64'd0);
    chk("rst_wbvalid", {63'd0, out_WbValid}, 64'd0);
    chk("rst_skip", {63'd0, out_Skip}, 64'd0);
    chk("rst_alurn", {32'd0, out_AluRn}, 64'd0);
    chk("rst_wbdata", {32'd0, out_WbData}, 64'd0);
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
    @(posedge in_Clk); #1;
    chk("rst_ready", {63'd0, out_Ready}, 64'd1);

    for (int i = 0; i < 11; i++) issue(tbl[i]);

    // Reset while a writeback is pending.
    in_Cond = 4'hE; in_Opcode = 4'h4; in_SetFlags = 1'b0; in_Rd = 4'h3;
    in_Rn_Val = 32'd1; in_Op2_Val = 32'd1; in_Valid = 1'b1;
    @(posedge in_Clk); #1;
    in_Valid = 1'b0;
    @(posedge in_Clk); #1;
    chk("pre_rst_wbvalid", {63'd0, out_WbValid}, 64'd1);
    chk("pre_rst_cnzv", {60'd0, out_CNZV}, 64'hB);
    in_Rst_N = 1'b0;
    #1;
    chk("midrst_wbvalid", {63'd0, out_WbValid}, 64'd0);
    chk("midrst_cnzv", {60'd0, out_CNZV}, 64'd0);
    chk("midrst_wbdata", {32'd0, out_WbData}, 64'd0);
    chk("midrst_alurn", {32'd0, out_AluRn}, 64'd0);
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
    @(posedge in_Clk); #1;
    chk("postrst_ready", {63'd0, out_Ready}, 64'd1);
    chk("postrst_wbvalid", {63'd0, out_WbValid}, 64'd0);
    flags_m = 4'h0;

    // Randomized instructions against the reference model.
    for (int n = 0; n < 80; n++) begin
      rv.cond  = 4'($urandom_range(0, 15));
      rv.op    = 4'($urandom_range(0, 15));
      rv.s     = 1'($urandom_range(0, 1));
      rv.rd    = 4'($urandom_range(0, 15));
      rv.rn    = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      rv.op2   = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      rv.shc   = 1'($urandom_range(0, 1));
      rv.stall = $urandom_range(0, 2);
      rv = ref_exec(rv, flags_m);
      issue(rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
